// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding and the
// instruction shown to decode when no real instruction has been fetched yet.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding slot used when a response arrives while decode
// is stalled on a live instruction.
module fetch_skid_buf #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic                     i_unload,
    input  logic                     i_flush,
    input  logic [DATA_WIDTH-1:0]    i_instr,
    input  logic [ADDRESS_WIDTH-1:0] i_pc,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_instr,
    output logic [ADDRESS_WIDTH-1:0] o_pc
);

    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_instr;
    logic [ADDRESS_WIDTH-1:0] r_pc;

    // Flush wins over load so a redirect never leaves a stale entry behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, keeps one request outstanding to
// instruction memory and feeds decode through a registered stage plus skid slot.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned               ADDRESS_WIDTH = 32,
    parameter int unsigned               DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pc_src_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    input  logic                     stall_d,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     valid_d,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic [1:0]               dbg_state
);

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

    fetch_state_t             r_state, w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_pc_q, r_req_pc;
    logic                     r_drop;
    logic                     r_valid_d;
    logic [DATA_WIDTH-1:0]    r_instr_d;
    logic [ADDRESS_WIDTH-1:0] r_pc_d, r_pc_plus4_d;

    logic                     w_req, w_grant, w_consume, w_resp_live;
    logic                     w_load_out, w_load_skid, w_unload_skid;
    logic                     w_skid_valid;
    logic [DATA_WIDTH-1:0]    w_skid_instr;
    logic [ADDRESS_WIDTH-1:0] w_skid_pc;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: if (w_grant) w_next_state = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (w_load_skid) w_next_state = S_HOLD;
                    else             w_next_state = S_FETCH;
                end
            end
            S_HOLD:  if (pc_src_e || !stall_d) w_next_state = S_FETCH;
            default: w_next_state = S_FETCH;
        endcase
    end

    // A response is only live if it was not made stale by an earlier or
    // simultaneous redirect.
    always_comb begin
        w_req         = !rst && (r_state == S_FETCH) && !(r_valid_d && stall_d);
        w_grant       = w_req && imem_gnt;
        w_consume     = r_valid_d && !stall_d;
        w_resp_live   = (r_state == S_WAIT) && imem_rvalid && !r_drop && !pc_src_e;
        w_load_out    = w_resp_live && (!r_valid_d || !stall_d);
        w_load_skid   = w_resp_live && r_valid_d && stall_d;
        w_unload_skid = (r_state == S_HOLD) && w_skid_valid && !stall_d && !pc_src_e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q   <= RESET_PC;
            r_req_pc <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (pc_src_e)     r_pc_q <= pc_target_e;
            else if (w_grant) r_pc_q <= r_pc_q + PC_STEP;

            if (w_grant) r_req_pc <= r_pc_q;

            if (w_grant)
                r_drop <= pc_src_e;
            else if (r_state == S_WAIT) begin
                if (imem_rvalid)   r_drop <= 1'b0;
                else if (pc_src_e) r_drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_d    <= 1'b0;
            r_instr_d    <= DATA_WIDTH'(NOP_INSTR);
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
        end else if (pc_src_e) begin
            r_valid_d <= 1'b0;
        end else if (w_load_out) begin
            r_valid_d    <= 1'b1;
            r_instr_d    <= imem_rdata;
            r_pc_d       <= r_req_pc;
            r_pc_plus4_d <= r_req_pc + PC_STEP;
        end else if (w_unload_skid) begin
            r_valid_d    <= 1'b1;
            r_instr_d    <= w_skid_instr;
            r_pc_d       <= w_skid_pc;
            r_pc_plus4_d <= w_skid_pc + PC_STEP;
        end else if (w_consume) begin
            r_valid_d <= 1'b0;
        end
    end

    fetch_skid_buf #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load_skid),
        .i_unload (w_unload_skid),
        .i_flush  (pc_src_e),
        .i_instr  (imem_rdata),
        .i_pc     (r_req_pc),
        .o_valid  (w_skid_valid),
        .o_instr  (w_skid_instr),
        .o_pc     (w_skid_pc)
    );

    assign imem_req   = w_req;
    assign imem_addr  = r_pc_q;
    assign valid_d    = r_valid_d;
    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then random
// traffic against a transaction-level model (pending-delivery queue + PC).
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        stall_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_PC      (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .stall_d     (stall_d),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .valid_d     (valid_d),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .dbg_state   (dbg_state)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: instructions awaiting consumption, in delivery order.
    ent_t        exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_addr;
    bit          m_outst;
    bit          m_stale;
    bit          m_fresh;

    // Memory responder state.
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input bit exp_req);
        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        check("imem_addr", imem_addr, m_pc);
        check("valid_d", {31'd0, valid_d}, {31'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            check("pc_d", pc_d, exp_q[0].pc);
            check("pc_plus4_d", pc_plus4_d, exp_q[0].pc + 32'd4);
            check("instr_d", instr_d, exp_q[0].instr);
        end else if (m_fresh) begin
            check("reset_instr_d", instr_d, 32'h0000_0013);
            check("reset_pc_d", pc_d, 32'd0);
            check("reset_pc_plus4_d", pc_plus4_d, 32'd0);
        end
    endtask

    // One clock cycle: drive at negedge, compare, advance model, wait a cycle.
    task automatic step(input bit i_rst, input bit i_src, input logic [31:0] i_tgt,
                        input bit i_stall, input bit i_gnt_en, input int i_lat);
        bit exp_req, grant, resp, consume;
        rst         = i_rst;
        pc_src_e    = i_src;
        pc_target_e = i_tgt;
        stall_d     = i_stall;
        imem_gnt    = i_gnt_en && !mem_busy;
        imem_rvalid = mem_busy && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_data(mem_addr) : $urandom();
        #1;
        exp_req = !i_rst && !m_outst && (exp_q.size() < 2) && !((exp_q.size() > 0) && i_stall);
        check_outputs(exp_req);

        grant = exp_req && imem_gnt;
        resp  = m_outst && imem_rvalid;

        if (imem_rvalid)   mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (grant) begin
            mem_busy = 1'b1;
            mem_cnt  = i_lat - 1;
            mem_addr = m_pc;
        end

        if (i_rst) begin
            m_pc    = 32'h0;
            m_outst = 1'b0;
            m_stale = 1'b0;
            m_fresh = 1'b1;
            exp_q.delete();
        end else if (i_src) begin
            exp_q.delete();
            m_pc = i_tgt;
            if (grant) begin
                m_outst = 1'b1;
                m_stale = 1'b1;
            end else if (resp) begin
                m_outst = 1'b0;
            end else if (m_outst) begin
                m_stale = 1'b1;
            end
        end else begin
            consume = (exp_q.size() > 0) && !i_stall;
            if (consume) void'(exp_q.pop_front());
            if (resp) begin
                m_outst = 1'b0;
                if (!m_stale) begin
                    exp_q.push_back('{pc: m_req_addr, instr: mem_data(m_req_addr)});
                    m_fresh = 1'b0;
                end
                m_stale = 1'b0;
            end
            if (grant) begin
                m_outst    = 1'b1;
                m_stale    = 1'b0;
                m_req_addr = m_pc;
                m_pc       = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit i_gnt_en, input int i_lat);
        step(1'b0, 1'b0, 32'h0, 1'b0, i_gnt_en, i_lat);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    endtask

    task automatic run_to_valid(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() > 0) break;
            idle(1'b1, 1);
        end
        check("deliver_within_budget", {31'd0, valid_d}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; pc_src_e = 1'b0; pc_target_e = '0; stall_d = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        m_pc = '0; m_req_addr = '0; m_outst = 0; m_stale = 0; m_fresh = 1;
        mem_busy = 0; mem_cnt = 0; mem_addr = '0;
        @(negedge clk);
        @(negedge clk);

        // Back-to-back fetch from reset, 1-cycle memory.
        do_reset();
        check("t1_first_addr", imem_addr, 32'h0);
        idle(1'b1, 1);
        idle(1'b1, 1);
        check("t1_valid0", {31'd0, valid_d}, 32'd1);
        check("t1_pc0", pc_d, 32'h0);
        check("t1_pc4_0", pc_plus4_d, 32'h4);
        idle(1'b1, 1);
        idle(1'b1, 1);
        check("t1_pc1", pc_d, 32'h4);
        check("t1_pc4_1", pc_plus4_d, 32'h8);
        idle(1'b1, 1);
        idle(1'b1, 1);
        check("t1_pc2", pc_d, 32'h8);
        check("t1_pc4_2", pc_plus4_d, 32'hC);
        check("t1_next_addr", imem_addr, 32'hC);

        // Stall holds the live instruction and blocks new requests.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        check("t2_hold_valid", {31'd0, valid_d}, 32'd1);
        check("t2_hold_pc", pc_d, 32'h8);
        check("t2_hold_addr", imem_addr, 32'hC);
        idle(1'b1, 1);
        idle(1'b1, 1);
        check("t2_next_pc", pc_d, 32'hC);

        // Redirect while a request is outstanding.
        do_reset();
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1);
        idle(1'b1, 3);
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1);
        idle(1'b0, 1);
        idle(1'b0, 1);
        check("t3_dropped", {31'd0, valid_d}, 32'd0);
        check("t3_addr", imem_addr, 32'h100);
        idle(1'b1, 1);
        idle(1'b1, 1);
        check("t3_valid", {31'd0, valid_d}, 32'd1);
        check("t3_pc", pc_d, 32'h100);
        check("t3_pc4", pc_plus4_d, 32'h104);
        check("t3_instr", instr_d, mem_data(32'h100));

        // Redirect in the same cycle as a grant.
        step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1);
        step(1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 1);
        idle(1'b0, 1);
        check("t4_dropped", {31'd0, valid_d}, 32'd0);
        check("t4_addr", imem_addr, 32'h80);
        run_to_valid(10);
        check("t4_pc", pc_d, 32'h80);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1);
        idle(1'b1, 1);
        check("t5_wrap_addr", imem_addr, 32'h0);
        idle(1'b0, 1);
        check("t5_pc", pc_d, 32'hFFFF_FFFC);
        check("t5_pc4", pc_plus4_d, 32'h0);

        // Reset while waiting; the late response must not be delivered.
        do_reset();
        idle(1'b1, 3);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        idle(1'b1, 1);
        check("t6_no_deliver", {31'd0, valid_d}, 32'd0);
        check("t6_addr", imem_addr, 32'h0);
        idle(1'b1, 1);
        idle(1'b1, 1);
        check("t6_valid", {31'd0, valid_d}, 32'd1);
        check("t6_pc", pc_d, 32'h0);
        check("t6_instr", instr_d, mem_data(32'h0));

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit          r_rst, r_src, r_stall, r_gnt;
            logic [31:0] r_tgt;
            r_rst   = ($urandom_range(0, 199) == 0);
            r_src   = ($urandom_range(0, 9) == 0);
            r_stall = ($urandom_range(0, 2) == 0);
            r_gnt   = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 7))
                0:       r_tgt = $urandom();
                1:       r_tgt = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
                default: r_tgt = $urandom() & 32'h0000_0FFC;
            endcase
            step(r_rst, r_src, r_tgt, r_stall, r_gnt, $urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
